// File: rtl/car_pkg.sv
// rtl/car_pkg.sv - shared command/state types and phase pattern ROM for car sensor benches
package car_pkg;

  typedef enum logic [1:0] {ENTER, EXIT, BALK, PED} cmd_t;
  typedef enum logic [1:0] {IDLE, PHASE, GAP} drv_state_t;

  // {a,b} for phase idx of a command; consecutive entries differ in one bit only
  function automatic logic [1:0] phase_pat(cmd_t cmd, logic [1:0] idx);
    logic [1:0] pat;
    pat = 2'b00;
    case (cmd)
      ENTER: pat = (idx == 2'd0) ? 2'b10 : (idx == 2'd1) ? 2'b11 : 2'b01;
      EXIT:  pat = (idx == 2'd0) ? 2'b01 : (idx == 2'd1) ? 2'b11 : 2'b10;
      BALK:  pat = (idx == 2'd1) ? 2'b11 : 2'b10;
      PED:   pat = 2'b10;
      default: pat = 2'b00;
    endcase
    return pat;
  endfunction

  function automatic logic [1:0] phase_len(cmd_t cmd);
    return (cmd == PED) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - up-counter that flags the last cycle of a MAX-cycle interval
module dwell_timer #(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (tick && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == W'(MAX - 1));

endmodule

// File: rtl/car_sensor_driver.sv
// rtl/car_sensor_driver.sv - plays photo-sensor a/b phase sequences for one command per handshake
module car_sensor_driver #(
  parameter int DWELL = 3,
  parameter int GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_cmd,
  output logic       req_ready,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [7:0] sent_cnt
);

  import car_pkg::*;

  localparam logic [1:0] ST_IDLE  = car_pkg::IDLE;
  localparam logic [1:0] ST_PHASE = car_pkg::PHASE;
  localparam logic [1:0] ST_GAP   = car_pkg::GAP;

  logic [1:0] state;
  cmd_t       cmd_q;
  logic [1:0] idx;
  logic       accept;
  logic       last_phase;
  logic       dwell_load;
  logic       dwell_tick;
  logic       dwell_exp;
  logic       gap_load;
  logic       gap_tick;
  logic       gap_exp;

  assign req_ready  = (state == ST_IDLE);
  assign busy       = ~req_ready;
  assign accept     = req_valid && req_ready;
  assign last_phase = (idx == (phase_len(cmd_q) - 2'd1));

  assign dwell_load = accept || ((state == ST_PHASE) && dwell_exp && !last_phase);
  assign dwell_tick = (state == ST_PHASE) && !dwell_exp;
  assign gap_load   = (state == ST_PHASE) && dwell_exp && last_phase;
  assign gap_tick   = (state == ST_GAP);

  dwell_timer #(.MAX(DWELL)) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .load    (dwell_load),
    .tick    (dwell_tick),
    .expired (dwell_exp)
  );

  dwell_timer #(.MAX(GAP)) u_gap (
    .clk     (clk),
    .reset   (reset),
    .load    (gap_load),
    .tick    (gap_tick),
    .expired (gap_exp)
  );

  // a/b are registered so the first pattern appears the cycle after accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cmd_q    <= ENTER;
      idx      <= 2'd0;
      a        <= 1'b0;
      b        <= 1'b0;
      done     <= 1'b0;
      sent_cnt <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q  <= cmd_t'(req_cmd);
            idx    <= 2'd0;
            {a, b} <= phase_pat(cmd_t'(req_cmd), 2'd0);
            state  <= ST_PHASE;
          end
        end
        ST_PHASE: begin
          if (dwell_exp) begin
            if (last_phase) begin
              {a, b}   <= 2'b00;
              done     <= 1'b1;
              sent_cnt <= sent_cnt + 8'd1;
              state    <= ST_GAP;
            end else begin
              idx    <= idx + 2'd1;
              {a, b} <= phase_pat(cmd_q, idx + 2'd1);
            end
          end
        end
        ST_GAP: begin
          if (gap_exp) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
